vec_reduce_acc: RTL
===================

# vec_reduce_acc

Consumes the element-wise product stream from the vector multiplier and reduces each frame to one signed scalar. Per accepted beat, all VECTOR_LEN signed elements are summed; beat sums accumulate across the frame until the beat flagged `last_i`. The frame total is then presented on a registered valid/ready output. Sits between the vector multiplier and the word-detect scoring logic.

## Interface
- BW_I, 16, signed element width of input vector (matches multiplier output width)
- VECTOR_LEN, 13, elements per beat
- BW_O, 32, signed accumulator/output width
- clk_i  in  1  clock, all logic on rising edge
- rst_i  in  1  reset, synchronous, active-high
- data_i  in  VECTOR_LEN*BW_I  packed signed elements, element k at bits [(k+1)*BW_I-1 : k*BW_I]
- valid_i  in  1  input beat valid
- last_i  in  1  final beat of frame, qualified by valid_i
- ready_o  out  1  block accepts beat this cycle
- data_o  out  BW_O  signed frame total
- valid_o  out  1  data_o valid, held until accepted
- ready_i  in  1  downstream accepts data_o

## Operation
- Beat accepted when valid_i & ready_o. data_i/last_i ignored otherwise.
- Stage 1 (reduce): beat_sum = sum of VECTOR_LEN elements, each sign-extended to BW_O. Registered as s1_sum, s1_last, s1_valid.
- Stage 2 (accumulate): out_free = !valid_o | ready_i. s2_take = s1_valid & (!s1_last | out_free).
  - s2_take & !s1_last: acc <= acc + s1_sum.
  - s2_take & s1_last: data_o <= acc + s1_sum; valid_o <= 1; acc <= 0.
  - valid_o & ready_i with no new last taken: valid_o <= 0.
- ready_o = !s1_valid | s2_take. Combinational from ready_i; no combinational path from valid_i to ready_o.
- Arithmetic wraps modulo 2^BW_O, no saturation, no overflow flag. With defaults, a single beat cannot overflow.
- Every frame ends with a beat carrying last_i, so there are no empty frames. A single-beat frame is legal.
- Implicit states per frame: IDLE (acc=0), ACCUM (acc holds partial), HOLD (valid_o=1 awaiting ready_i). Accumulation of the next frame proceeds during HOLD. Only a pending last beat stalls.

## Timing
- Reset values: valid_o=0, data_o=0, ready_o=1 (s1 empty), acc=0, s1_valid=0.
- Latency: last beat accepted at cycle t gives valid_o=1 at t+2, provided out_free held at t+1.
- Throughput: one beat per cycle. With ready_i=1, back-to-back single-beat frames yield one result per cycle.
- Backpressure: if s1 holds a last beat while valid_o=1 & ready_i=0, then s2_take=0 and ready_o=0. Release is the same cycle ready_i rises.
- data_o and valid_o are stable while valid_o & !ready_i.
- Simultaneous drain and new last: valid_o stays 1 and data_o updates to the new total. No bubble.
- rst_i mid-frame: partial acc, s1 content and pending output are discarded. The next accepted beat starts a new frame.

## Structure
- Shared package `vec_pkg`: default BW_I/VECTOR_LEN/BW_O constants, shared with the vector multiplier for width consistency.
- Sub-module `vec_sum_tree`: combinational signed adder tree, VECTOR_LEN x BW_I in, BW_O out. Parameterised, reusable by other reductions.
- Top holds the stage-1 register, accumulator, output register and handshake logic.

## Test plan
- Single-beat frame, all 13 elements = 1, last_i=1, ready_i=1 → valid_o at t+2, data_o=13, valid_o low next cycle.
- Three-beat frame, all elements 0xFFFF (-1), last on third beat → data_o=0xFFFFFFD9 (-39), exactly one valid_o pulse.
- Extremes: one beat all elements 0x8000, a second last beat all 0x7FFF → data_o = -425984 + 425971 = -13.
- Backpressure: frame A (sum 13) completes with ready_i=0, then frame B single beat (sum 26) is offered. Required: ready_o=0 once B sits in s1, and data_o=13 stable. Raise ready_i: A accepted, then data_o=26 the next cycle.
- Reset mid-frame: two non-last beats summing 100, rst_i for 1 cycle, then one last beat summing 5 → data_o=5.
- Streaming: 8 consecutive single-beat frames with sums 1..8, ready_i=1 → data_o=1..8 on 8 consecutive cycles, ready_o constantly 1.

Source files
------------

// File: rtl/vec_pkg.sv
// Shared width constants for the vector datapath (multiplier -> reducer ->
// scoring). The multiplier and the reducer both import this package so that
// their element widths and vector lengths always agree.
package vec_pkg;

  // Default signed element width of one vector lane (multiplier output width)
  localparam int DEF_BW_I = 16;

  // Default number of lanes carried in one beat
  localparam int DEF_VECTOR_LEN = 13;

  // Default signed accumulator / frame-total width
  localparam int DEF_BW_O = 32;

  // Smallest power of two that can hold n leaves, used to size a balanced
  // binary adder tree. A single leaf needs no adders at all.
  function automatic int treeLeaves(input int n);
    int p;
    p = 1;
    while (p < n) begin
      p = p * 2;
    end
    return p;
  endfunction

endpackage

// File: rtl/vec_reduce_acc_if.sv
// Handshake bundle for the frame reducer: the product-vector input stream
// (data/valid/last with ready back) and the frame-total output stream
// (data/valid with ready back). Signal suffixes are named from the reducer's
// point of view, so the reducer uses the slave modport and whoever feeds it
// and drains it uses the master modport.
interface vec_reduce_acc_if #(
  parameter int BW_I       = vec_pkg::DEF_BW_I,
  parameter int VECTOR_LEN = vec_pkg::DEF_VECTOR_LEN,
  parameter int BW_O       = vec_pkg::DEF_BW_O
);

  // Input beat: VECTOR_LEN packed signed lanes, lane k at [(k+1)*BW_I-1 : k*BW_I]
  logic [VECTOR_LEN*BW_I-1:0] data_i;
  logic                       valid_i;
  logic                       last_i;
  logic                       ready_o;

  // Output frame total, held while valid_o is high and ready_i is low
  logic [BW_O-1:0]            data_o;
  logic                       valid_o;
  logic                       ready_i;

  // Reducer side
  modport slave (
    input  data_i,
    input  valid_i,
    input  last_i,
    input  ready_i,
    output ready_o,
    output data_o,
    output valid_o
  );

  // Producer / consumer side
  modport master (
    output data_i,
    output valid_i,
    output last_i,
    output ready_i,
    input  ready_o,
    input  data_o,
    input  valid_o
  );

endinterface

// File: rtl/vec_sum_tree.sv
// Combinational signed reduction of VECTOR_LEN packed lanes into one wide
// sum. Lanes are sign-extended to BW_O first, then added pairwise in a
// balanced binary tree so the depth grows with log2(VECTOR_LEN) rather than
// linearly. The tree is padded with zero leaves up to a power of two.
// Arithmetic wraps modulo 2^BW_O.
module vec_sum_tree
  import vec_pkg::*;
#(
  parameter int BW_I       = DEF_BW_I,
  parameter int VECTOR_LEN = DEF_VECTOR_LEN,
  parameter int BW_O       = DEF_BW_O
) (
  input  logic [VECTOR_LEN*BW_I-1:0] data_i,
  output logic [BW_O-1:0]            sum_o
);

  // Leaves sit at the bottom of a heap-ordered array: node i has children
  // 2i+1 and 2i+2, and the root (index 0) is the full sum.
  localparam int LEAVES = treeLeaves(VECTOR_LEN);
  localparam int NODES  = 2 * LEAVES - 1;

  logic [BW_O-1:0] node [NODES];

  // Build the tree bottom-up: leaves first, then every inner node from the
  // highest index down so that both children are always ready before use.
  always_comb begin : buildTree
    logic [BW_I-1:0] elem;
    elem = '0;
    for (int i = 0; i < NODES; i++) begin
      node[i] = '0;
    end
    for (int k = 0; k < VECTOR_LEN; k++) begin
      elem = data_i[k*BW_I +: BW_I];
      node[LEAVES-1+k] = {{(BW_O-BW_I){elem[BW_I-1]}}, elem};
    end
    for (int k = VECTOR_LEN; k < LEAVES; k++) begin
      node[LEAVES-1+k] = '0;
    end
    for (int i = LEAVES - 2; i >= 0; i--) begin
      node[i] = node[2*i+1] + node[2*i+2];
    end
  end

  assign sum_o = node[0];

endmodule

// File: rtl/vec_reduce_acc.sv
// Frame reducer between the vector multiplier and the word-detect scoring.
// Each accepted beat of VECTOR_LEN signed products is summed by the adder
// tree and captured in stage 1. Stage 2 folds beat sums into a running
// frame accumulator; the beat carrying last produces the frame total in a
// registered valid/ready output slot and clears the accumulator.
//
// Frame life cycle, implicit in the registers below:
//   IDLE  - accumulator is zero, nothing pending
//   ACCUM - accumulator holds a partial frame
//   HOLD  - output slot full, waiting for the consumer
// The next frame keeps accumulating during HOLD; only a last beat that
// finds the output slot still occupied stalls the pipeline.
module vec_reduce_acc
  import vec_pkg::*;
#(
  parameter int BW_I       = DEF_BW_I,
  parameter int VECTOR_LEN = DEF_VECTOR_LEN,
  parameter int BW_O       = DEF_BW_O
) (
  input  logic              clk_i,
  input  logic              rst_i,
  vec_reduce_acc_if.slave   bus
);

  // Combinational sum of the beat currently on the input bus
  logic [BW_O-1:0] beatSum;

  // Stage 1: one reduced beat waiting for the accumulator
  logic            s1Valid_q, s1Valid_d;
  logic            s1Last_q,  s1Last_d;
  logic [BW_O-1:0] s1Sum_q,   s1Sum_d;

  // Stage 2: running partial of the current frame
  logic [BW_O-1:0] acc_q,     acc_d;

  // Output slot
  logic [BW_O-1:0] dataOut_q, dataOut_d;
  logic            validOut_q, validOut_d;

  // Handshake helpers
  logic            outFree;
  logic            s2Take;
  logic            readyIn;
  logic [BW_O-1:0] frameTotal;

  vec_sum_tree #(
    .BW_I       (BW_I),
    .VECTOR_LEN (VECTOR_LEN),
    .BW_O       (BW_O)
  ) u_sumTree (
    .data_i (bus.data_i),
    .sum_o  (beatSum)
  );

  // The output slot can take a new total if it is empty or is being drained
  // this cycle. A non-last beat never needs the slot, so it always moves on;
  // that is what lets the next frame accumulate while a result is held.
  // ready depends on ready_i and registered state only, never on valid_i.
  always_comb begin
    outFree    = ~validOut_q | bus.ready_i;
    s2Take     = s1Valid_q & (~s1Last_q | outFree);
    readyIn    = ~s1Valid_q | s2Take;
    frameTotal = acc_q + s1Sum_q;
  end

  // Next-state for both pipeline stages and the output slot. A drain and a
  // new last in the same cycle keep valid high and swap in the new total.
  always_comb begin
    s1Valid_d  = s1Valid_q;
    s1Last_d   = s1Last_q;
    s1Sum_d    = s1Sum_q;
    acc_d      = acc_q;
    dataOut_d  = dataOut_q;
    validOut_d = validOut_q;

    if (readyIn) begin
      s1Valid_d = bus.valid_i;
      if (bus.valid_i) begin
        s1Sum_d  = beatSum;
        s1Last_d = bus.last_i;
      end
    end

    if (validOut_q && bus.ready_i) begin
      validOut_d = 1'b0;
    end

    if (s2Take) begin
      if (s1Last_q) begin
        dataOut_d  = frameTotal;
        validOut_d = 1'b1;
        acc_d      = '0;
      end else begin
        acc_d      = frameTotal;
      end
    end
  end

  // State registers; reset drops any partial frame, staged beat and
  // pending result so the next accepted beat starts a fresh frame.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      s1Valid_q  <= 1'b0;
      s1Last_q   <= 1'b0;
      s1Sum_q    <= '0;
      acc_q      <= '0;
      dataOut_q  <= '0;
      validOut_q <= 1'b0;
    end else begin
      s1Valid_q  <= s1Valid_d;
      s1Last_q   <= s1Last_d;
      s1Sum_q    <= s1Sum_d;
      acc_q      <= acc_d;
      dataOut_q  <= dataOut_d;
      validOut_q <= validOut_d;
    end
  end

  assign bus.ready_o = readyIn;
  assign bus.data_o  = dataOut_q;
  assign bus.valid_o = validOut_q;

endmodule
